// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, instruction size, reset NOP.
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > PC+4), redirect targets forced word-aligned.
// Purely combinational, zero latency, no flow control.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_pcimm,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_pc_seq;

  // Natural wrap of the adder gives PC+4 modulo 2^XLEN
  assign w_pc_seq   = i_pc + XLEN'(INSTR_BYTES);
  assign o_redirect = i_jump_en | i_branch_taken;

  always_comb begin
    o_next_pc = w_pc_seq;
    if (i_jump_en) begin
      o_next_pc = {i_jump_target[XLEN-1:2], 2'b00};
    end else if (i_branch_taken) begin
      o_next_pc = {i_pcimm[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem handshake, output register to decode.
// Zero-wait memory gives request in N, if_valid in N+2; if_ready=0 or stall holds output and issues no request.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] PC,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] PCimm,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
);

  fetch_state_t    r_state,    w_state_nxt;
  logic [XLEN-1:0] r_pc,       w_pc_nxt;
  logic [XLEN-1:0] r_req_pc,   w_req_pc_nxt;
  logic            r_kill,     w_kill_nxt;
  logic            r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0] r_if_pc,    w_if_pc_nxt;
  logic [XLEN-1:0] r_if_instr, w_if_instr_nxt;

  logic            w_redirect;
  logic [XLEN-1:0] w_next_pc;
  logic            w_imem_req;
  logic            w_accept;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .i_pc           (r_pc),
    .i_jump_en      (jump_en),
    .i_jump_target  (jump_target),
    .i_branch_taken (branch_taken),
    .i_pcimm        (PCimm),
    .o_redirect     (w_redirect),
    .o_next_pc      (w_next_pc)
  );

  assign w_imem_req = (r_state == S_REQ) && !stall;
  assign w_accept   = w_imem_req && imem_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_pc_nxt   = r_req_pc;
    w_kill_nxt     = r_kill;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redirect) w_pc_nxt = w_next_pc;
      end
      S_REQ: begin
        if (w_accept) begin
          // A redirect in the accept cycle leaves a stale request in flight
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = w_next_pc;
          w_kill_nxt   = w_redirect;
          w_state_nxt  = S_WAIT;
        end else if (w_redirect) begin
          w_pc_nxt = w_next_pc;
        end
      end
      S_WAIT: begin
        if (w_redirect) w_pc_nxt = w_next_pc;
        if (imem_valid) begin
          if (r_kill || w_redirect) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_req_pc;
            w_if_instr_nxt = imem_rdata;
            w_state_nxt    = S_HOLD;
          end
        end else if (w_redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt       = w_next_pc;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end else if (r_if_valid) begin
          if (if_ready) begin
            w_if_valid_nxt = 1'b0;
            w_state_nxt    = stall ? S_HOLD : S_REQ;
          end
        end else if (!stall) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= XLEN'(NOP_INSTR);
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
    end
  end

  assign PC        = r_pc;
  assign imem_addr = r_pc;
  assign imem_req  = w_imem_req;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed per-cycle vectors for pc_fetch_unit plus a hand-written async-reset sequence.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        branch_taken;
  logic [31:0] PCimm;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .branch_taken (branch_taken),
    .PCimm        (PCimm),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_ready     (if_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] pcimm;
    logic        jen;
    logic [31:0] jt;
    logic        stl;
    logic        rdy;
    logic        vld;
    logic [31:0] rdata;
    logic        ifrdy;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic [31:0] e_ifi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic br, input logic [31:0] pcimm, input logic jen,
                              input logic [31:0] jt, input logic stl, input logic rdy,
                              input logic vld, input logic [31:0] rdata, input logic ifrdy,
                              input logic [31:0] e_pc, input logic e_req, input logic e_ifv,
                              input logic [31:0] e_ifpc, input logic [31:0] e_ifi);
    vec_t v;
    v.br = br; v.pcimm = pcimm; v.jen = jen; v.jt = jt; v.stl = stl;
    v.rdy = rdy; v.vld = vld; v.rdata = rdata; v.ifrdy = ifrdy;
    v.e_pc = e_pc; v.e_req = e_req; v.e_ifv = e_ifv; v.e_ifpc = e_ifpc; v.e_ifi = e_ifi;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    branch_taken = v.br;  PCimm      = v.pcimm;
    jump_en      = v.jen; jump_target = v.jt;
    stall        = v.stl; imem_ready = v.rdy;
    imem_valid   = v.vld; imem_rdata = v.rdata;
    if_ready     = v.ifrdy;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // cycle-by-cycle: inputs for the cycle, then outputs expected during that cycle
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0,     0, 32'h0,   0, 0, 32'h0, NOP));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'h0,   1, 0, 32'h0, NOP));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 1, 32'h11111111, 0, 32'h4, 0, 0, 32'h0, NOP));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,   0, 0,     0, 1, 0, 0,     0, 32'h4,   0, 1, 32'h0, 32'h11111111));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 32'h4,   0, 1, 32'h0, 32'h11111111));
    vecs.push_back(mk(1, 32'h22, 0, 0,    0, 1, 0, 0,     0, 32'h4,   1, 0, 32'h0, 32'h11111111));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 1, 32'hDEADBEEF, 0, 32'h20, 0, 0, 32'h0, 32'h11111111));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'h20,  1, 0, 32'h0, 32'h11111111));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 1, 32'h22222222, 0, 32'h24, 0, 0, 32'h0, 32'h11111111));
    vecs.push_back(mk(1, 32'h20, 1, 32'h100, 0, 0, 0, 0, 1, 32'h24,  0, 1, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0,     0, 32'h100, 1, 0, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     0, 0,     1, 1, 0, 0,     0, 32'h100, 0, 0, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h100, 1, 0, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'hFFFFFFFC, 1, 0, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 32'h0,   0, 0, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     0, 0,     1, 0, 1, 32'h33333333, 0, 32'h0, 0, 0, 32'h20, 32'h22222222));
    vecs.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     1, 32'h0,   0, 1, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 32'h0,   0, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'h0,   0, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'h0,   1, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     1, 32'h80, 0, 0, 1, 32'h44444444, 0, 32'h4, 0, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'h80,  1, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(1, 32'h200, 0, 0,   0, 0, 0, 0,     0, 32'h84,  0, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 1, 32'h55555555, 0, 32'h200, 0, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 1, 0, 0,     0, 32'h200, 1, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 1, 32'h66666666, 0, 32'h204, 0, 0, 32'hFFFFFFFC, 32'h33333333));
    vecs.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0,     0, 32'h204, 0, 1, 32'h200, 32'h66666666));

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc", PC, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ifv", {31'd0, if_valid}, 32'd0);
    check("rst_ifpc", if_pc, 32'h0);
    check("rst_ifi", if_instr, NOP);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_pc", i), PC, vecs[i].e_pc);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_pc);
      check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_ifv", i), {31'd0, if_valid}, {31'd0, vecs[i].e_ifv});
      check($sformatf("v%0d_ifpc", i), if_pc, vecs[i].e_ifpc);
      check($sformatf("v%0d_ifi", i), if_instr, vecs[i].e_ifi);
      @(negedge clk);
    end

    // Drain HOLD, issue a request, then hit async reset while it is outstanding
    idle_inputs();
    if_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    imem_ready = 1'b1;
    #1;
    check("seq_req", {31'd0, imem_req}, 32'd1);
    check("seq_addr", imem_addr, 32'h204);
    @(negedge clk);
    idle_inputs();
    #1;
    check("wait_pc", PC, 32'h208);
    reset = 1'b1;
    #1;
    check("arst_pc", PC, 32'h0);
    check("arst_ifv", {31'd0, if_valid}, 32'd0);
    check("arst_ifpc", if_pc, 32'h0);
    check("arst_ifi", if_instr, NOP);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h77777777;
    #1;
    check("late_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("late_ifv", {31'd0, if_valid}, 32'd0);
    check("late_ifi", if_instr, NOP);
    check("post_req", {31'd0, imem_req}, 32'd1);
    check("post_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    imem_valid = 1'b1;
    imem_rdata = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    #1;
    check("post_ifv", {31'd0, if_valid}, 32'd1);
    check("post_ifpc", if_pc, 32'h0);
    check("post_ifi", if_instr, 32'h12345678);
    check("post_pc", PC, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
